// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: default payload layout and the slot-count limit
// for pipeline_stage.
package cpu_types_pkg;

  localparam int PIPE_DEPTH_MAX = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } pipe_payload_t;

  localparam int PIPE_PAYLOAD_W = $bits(pipe_payload_t);

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register slot: a valid bit plus payload. Data is captured only
// on load, so an emptied slot keeps showing its last payload.
module pipe_slot #(
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (clear)     valid <= 1'b0;
      else if (load) valid <= 1'b1;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/pipeline_stage.sv
// Valid/ready pipeline stage of DEPTH slots with stall and flush.
// Define PIPE_SKID_EN to add a registered-ready skid entry at the input.
module pipeline_stage
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = PIPE_PAYLOAD_W,
  parameter int DEPTH  = 1
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       stall,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW    = $clog2(DEPTH+1);
  localparam int SLOTS = (DEPTH < 1) ? 1 : ((DEPTH > PIPE_DEPTH_MAX) ? PIPE_DEPTH_MAX : DEPTH);

  logic [SLOTS-1:0]  v;
  logic [SLOTS-1:0]  move;
  logic [SLOTS-1:0]  load;
  logic [SLOTS-1:0]  clear;
  logic [DATA_W-1:0] q [SLOTS];
  logic [DATA_W-1:0] d [SLOTS];
  logic              run;
  logic              slot_open0;
  logic              load0;
  logic [DATA_W-1:0] d0;

  assign run = !stall && !flush;

  // Walk from the output slot back: a slot moves when the slot ahead of it is
  // free now or is itself moving on this edge.
  always_comb begin
    logic free;
    move = '0;
    free = out_ready;
    for (int i = SLOTS-1; i >= 0; i--) begin
      move[i] = run && v[i] && free;
      free    = !v[i] || (run && v[i] && free);
    end
    slot_open0 = run && free;
  end

  always_comb begin
    load = '0;
    for (int i = 0; i < SLOTS; i++) d[i] = '0;
    load[0] = load0;
    d[0]    = d0;
    for (int i = 1; i < SLOTS; i++) begin
      load[i] = move[i-1];
      d[i]    = q[i-1];
    end
    for (int i = 0; i < SLOTS; i++) clear[i] = flush || (move[i] && !load[i]);
  end

`ifdef PIPE_SKID_EN
  logic              skid_v;
  logic              skid_v_n;
  logic              rdy_q;
  logic              in_fire;
  logic              to_skid;
  logic [DATA_W-1:0] skid_d;

  // Ready is registered; stall/flush only gate it so the hold/squash rules
  // still apply within the cycle.
  assign in_ready = rdy_q && run;
  assign in_fire  = in_valid && in_ready;
  assign to_skid  = !skid_v && in_fire && !slot_open0;
  assign load0    = skid_v ? slot_open0 : (in_fire && slot_open0);
  assign d0       = skid_v ? skid_d : in_data;

  always_comb begin
    skid_v_n = skid_v;
    if (flush)                     skid_v_n = 1'b0;
    else if (skid_v && slot_open0) skid_v_n = 1'b0;
    else if (to_skid)              skid_v_n = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
      skid_d <= '0;
    end else begin
      skid_v <= skid_v_n;
      rdy_q  <= !skid_v_n;
      if (to_skid) skid_d <= in_data;
    end
  end
`else
  assign in_ready = slot_open0;
  assign load0    = in_valid && slot_open0;
  assign d0       = in_data;
`endif

  always_comb begin
    int n;
    n = 0;
    for (int i = 0; i < SLOTS; i++) n += int'(v[i]);
`ifdef PIPE_SKID_EN
    n += int'(skid_v);
`endif
    if (n > SLOTS) n = SLOTS;
    count = CW'(n);
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    pipe_slot #(.DATA_W(DATA_W)) u_slot (
      .CLK   (CLK),
      .nRST  (nRST),
      .load  (load[g]),
      .clear (clear[g]),
      .d     (d[g]),
      .valid (v[g]),
      .q     (q[g])
    );
  end

  assign out_valid = v[SLOTS-1] && run;
  assign out_data  = q[SLOTS-1];

endmodule

// File: tb/tb_pipeline_stage.sv
// Directed bench for pipeline_stage at DEPTH=2: vector table plus reset,
// backpressure-toggle and drain sequences.
module tb_pipeline_stage;

  localparam int DW = 32;
  localparam int DP = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          in_valid, in_ready, out_valid, out_ready, stall, flush;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    count;

  always #5 CLK = ~CLK;

  pipeline_stage #(.DATA_W(DW), .DEPTH(DP)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall     (stall),
    .flush     (flush),
    .count     (count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        st;
    logic        fl;
    logic        ir;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  cnt;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                              input logic st, input logic fl, input logic ir,
                              input logic ov, input logic [31:0] od, input logic [1:0] cnt);
    vec_t r;
    r.iv = iv; r.d = d; r.ordy = ordy; r.st = st; r.fl = fl;
    r.ir = ir; r.ov = ov; r.od = od; r.cnt = cnt;
    return r;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic st, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  vec_t          tbl [30];
  logic          ir_a;
  int            sent, got;
  logic [31:0]   nxt_in, exp_out;

  initial begin
    // expected outputs are those seen during the cycle, before the edge
    tbl[0]  = mk(1, 32'h01, 1, 0, 0, 1, 0, 32'h00, 0);
    tbl[1]  = mk(1, 32'h02, 1, 0, 0, 1, 0, 32'h00, 1);
    tbl[2]  = mk(1, 32'h03, 1, 0, 0, 1, 1, 32'h01, 2);
    tbl[3]  = mk(0, 32'h00, 1, 0, 0, 1, 1, 32'h02, 2);
    tbl[4]  = mk(0, 32'h00, 1, 0, 0, 1, 1, 32'h03, 1);
    tbl[5]  = mk(0, 32'h00, 0, 0, 0, 1, 0, 32'h03, 0);
    tbl[6]  = mk(1, 32'h11, 0, 0, 0, 1, 0, 32'h03, 0);
    tbl[7]  = mk(1, 32'h12, 0, 0, 0, 1, 0, 32'h03, 1);
    tbl[8]  = mk(1, 32'h13, 0, 0, 0, 0, 1, 32'h11, 2);
    tbl[9]  = mk(1, 32'h13, 0, 0, 0, 0, 1, 32'h11, 2);
    tbl[10] = mk(1, 32'h13, 1, 0, 0, 1, 1, 32'h11, 2);
    tbl[11] = mk(0, 32'h00, 1, 0, 0, 1, 1, 32'h12, 2);
    tbl[12] = mk(0, 32'h00, 1, 0, 0, 1, 1, 32'h13, 1);
    tbl[13] = mk(1, 32'h21, 0, 0, 0, 1, 0, 32'h13, 0);
    tbl[14] = mk(1, 32'h22, 0, 0, 0, 1, 0, 32'h13, 1);
    tbl[15] = mk(1, 32'h09, 1, 1, 1, 0, 0, 32'h21, 2);
    tbl[16] = mk(0, 32'h00, 1, 0, 0, 1, 0, 32'h21, 0);
    tbl[17] = mk(0, 32'h00, 1, 0, 0, 1, 0, 32'h21, 0);
    tbl[18] = mk(1, 32'h31, 1, 0, 0, 1, 0, 32'h21, 0);
    tbl[19] = mk(1, 32'h32, 1, 1, 0, 0, 0, 32'h21, 1);
    tbl[20] = mk(1, 32'h32, 1, 1, 0, 0, 0, 32'h21, 1);
    tbl[21] = mk(1, 32'h32, 1, 1, 0, 0, 0, 32'h21, 1);
    tbl[22] = mk(0, 32'h00, 1, 0, 0, 1, 0, 32'h21, 1);
    tbl[23] = mk(0, 32'h00, 1, 0, 0, 1, 1, 32'h31, 1);
    tbl[24] = mk(1, 32'h41, 0, 0, 0, 1, 0, 32'h31, 0);
    tbl[25] = mk(0, 32'h00, 0, 0, 0, 1, 0, 32'h31, 1);
    tbl[26] = mk(0, 32'h00, 1, 1, 0, 0, 0, 32'h41, 1);
    tbl[27] = mk(0, 32'h00, 1, 0, 0, 1, 1, 32'h41, 1);
    tbl[28] = mk(1, 32'h51, 1, 0, 1, 0, 0, 32'h41, 0);
    tbl[29] = mk(0, 32'h00, 1, 0, 0, 1, 0, 32'h41, 0);

    nRST = 1'b0;
    drive(1, 32'hDEADBEEF, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset count",     64'(count),     64'd0);
    check("reset out_data",  64'(out_data),  64'd0);
    check("reset in_ready",  64'(in_ready),  64'd1);
    nRST = 1'b1;

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].st, tbl[i].fl);
      #1;
`ifndef PIPE_SKID_EN
      check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
`endif
      check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      check($sformatf("v%0d out_data", i),  64'(out_data),  64'(tbl[i].od));
      check($sformatf("v%0d count", i),     64'(count),     64'(tbl[i].cnt));
      tick();
    end

    // reset asserted while full discards everything at once
    drive(1, 32'h61, 0, 0, 0);
    tick();
    drive(1, 32'h62, 0, 0, 0);
    tick();
    check("prefill count", 64'(count), 64'd2);
    #2;
    nRST = 1'b0;
    #1;
    check("midreset count",     64'(count),     64'd0);
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset out_data",  64'(out_data),  64'd0);
    tick();
    drive(1, 32'h71, 1, 0, 0);
    nRST = 1'b1;
    tick();
    drive(0, 32'h0, 1, 0, 0);
    check("post-reset count1",  64'(count),     64'd1);
    check("post-reset ov1",     64'(out_valid), 64'd0);
    tick();
    check("post-reset ov2",     64'(out_valid), 64'd1);
    check("post-reset data2",   64'(out_data),  64'h71);
    tick();
    check("post-reset drained", 64'(count),     64'd0);

    // out_ready toggling every cycle under constant in_valid
    sent = 0; got = 0;
    nxt_in = 32'h100; exp_out = 32'h100;
    out_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1;
      in_data  = nxt_in;
      ir_a     = in_ready;
      out_ready = ~out_ready;
      #1;
`ifdef PIPE_SKID_EN
      check($sformatf("toggle c%0d in_ready stable", c), 64'(in_ready), 64'(ir_a));
`endif
      if (out_valid && out_ready) begin
        check($sformatf("toggle c%0d order", c), 64'(out_data), 64'(exp_out));
        exp_out++;
        got++;
      end
      if (in_valid && in_ready) begin
        nxt_in++;
        sent++;
      end
      tick();
    end
    drive(0, 32'h0, 1, 0, 0);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid && out_ready) begin
        check($sformatf("drain c%0d order", c), 64'(out_data), 64'(exp_out));
        exp_out++;
        got++;
      end
      tick();
    end
    check("toggle out==in count", 64'(got), 64'(sent));
    check("toggle accepted some", 64'(sent >= 10), 64'd1);
    check("toggle final count",   64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
